// File: rtl/instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// instr_encoder_loader
//
// Writer-side companion of the instruction decode path. It takes RV32I
// instruction requests (op kind, register indices, signed immediate) one at a
// time, encodes each into a 32-bit instruction word and writes the words to
// consecutive instruction-memory byte addresses, starting from a programmable
// base. Only the subset the control unit decodes is supported:
// ADDI SLTI ORI ANDI LW SW BEQ BNE BLT BGE BLTU BGEU JAL JALR.
//
// Build option:
//   ENCODER_RANGE_CHECK_EN  when defined, immediates outside the field range
//                           (or odd B/J offsets) are rejected: a NOP is written
//                           and err is set. When undefined, immediates are
//                           silently truncated to the field width.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           begin a session (only looked at in IDLE)
//   base_addr       first byte address of the session, bits [1:0] ignored
//   op_valid/ready  request handshake
//   op_kind         0 ADDI,1 SLTI,2 ORI,3 ANDI,4 LW,5 SW,6 BEQ,7 BNE,8 BLT,
//                   9 BGE,10 BLTU,11 BGEU,12 JAL,13 JALR, 14-15 illegal
//   rd, rs1, rs2    register indices
//   imm             signed immediate / byte offset
//   last            marks the final request of the session
//   mem_we/addr/wdata  instruction-memory write port
//   busy            session active (ACCEPT, WRITE, DONE)
//   done            one-cycle end-of-session pulse
//   err             sticky error, cleared by the next start
//   count           words written in the current session
//   dbg_state       current FSM state (0 IDLE, 1 ACCEPT, 2 WRITE, 3 DONE)
//
// Handshake: a request transfers on a rising edge where op_valid and op_ready
// are both 1. op_ready is 1 only in ACCEPT and never depends on op_valid; the
// requester must hold the request fields stable while op_valid is 1 and
// op_ready is 0. op_valid seen outside ACCEPT is never consumed.
// -----------------------------------------------------------------------------
module instr_encoder_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [3:0]            op_kind,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    input  logic                  last,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] count,
    output logic [1:0]            dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCEPT = 2'd1,
        WRITE  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FMT_I = 2'd0,
        FMT_S = 2'd1,
        FMT_B = 2'd2,
        FMT_J = 2'd3
    } fmt_t;

    localparam logic [31:0] NOP        = 32'h0000_0013;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  last_q;
    logic                  err_q;

    logic                  accept;
    logic                  top_word;

    // ------------------------------------------------------------------
    // Encoder (combinational, feeds only the word register)
    // ------------------------------------------------------------------
    fmt_t        fmt;
    logic [2:0]  f3;
    logic [6:0]  opc;
    logic        kind_bad;
    logic        imm_bad;
    logic [31:0] raw_word;
    logic [31:0] enc_word;
    logic        enc_bad;

    always_comb begin
        fmt      = FMT_I;
        f3       = 3'b000;
        opc      = OPC_OPIMM;
        kind_bad = 1'b0;
        case (op_kind)
            4'd0:  f3 = 3'b000;
            4'd1:  f3 = 3'b010;
            4'd2:  f3 = 3'b110;
            4'd3:  f3 = 3'b111;
            4'd4:  begin opc = OPC_LOAD;  f3 = 3'b010; end
            4'd5:  begin opc = OPC_STORE; f3 = 3'b010; fmt = FMT_S; end
            4'd6:  begin opc = OPC_BRANCH; f3 = 3'b000; fmt = FMT_B; end
            4'd7:  begin opc = OPC_BRANCH; f3 = 3'b001; fmt = FMT_B; end
            4'd8:  begin opc = OPC_BRANCH; f3 = 3'b100; fmt = FMT_B; end
            4'd9:  begin opc = OPC_BRANCH; f3 = 3'b101; fmt = FMT_B; end
            4'd10: begin opc = OPC_BRANCH; f3 = 3'b110; fmt = FMT_B; end
            4'd11: begin opc = OPC_BRANCH; f3 = 3'b111; fmt = FMT_B; end
            4'd12: begin opc = OPC_JAL;  fmt = FMT_J; end
            4'd13: begin opc = OPC_JALR; f3 = 3'b000; end
            default: kind_bad = 1'b1;
        endcase
    end

`ifdef ENCODER_RANGE_CHECK_EN
    // A value fits a signed N-bit field when every bit from N-1 upwards
    // equals the sign, i.e. that slice is all zeros or all ones.
    always_comb begin
        imm_bad = 1'b0;
        case (fmt)
            FMT_I, FMT_S: imm_bad = !((&imm[31:11]) || ~(|imm[31:11]));
            FMT_B:        imm_bad = !((&imm[31:12]) || ~(|imm[31:12])) || imm[0];
            default:      imm_bad = !((&imm[31:20]) || ~(|imm[31:20])) || imm[0];
        endcase
    end

    logic unused_bits;
    assign unused_bits = ^base_addr[1:0];
`else
    assign imm_bad = 1'b0;

    // Without range checking the upper immediate bits are simply dropped.
    logic unused_bits;
    assign unused_bits = ^{base_addr[1:0], imm[31:21]};
`endif

    always_comb begin
        raw_word = '0;
        case (fmt)
            FMT_I:   raw_word = {imm[11:0], rs1, f3, rd, opc};
            FMT_S:   raw_word = {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
            FMT_B:   raw_word = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
            default: raw_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
        endcase
        enc_bad  = kind_bad | imm_bad;
        enc_word = enc_bad ? NOP : raw_word;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    assign accept   = (state == ACCEPT) && op_valid;
    // The word being written sits at the highest word address.
    assign top_word = &addr_q[ADDR_WIDTH-1:2];

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = ACCEPT;
            ACCEPT:  if (op_valid) state_nx = WRITE;
            WRITE:   state_nx = (last_q || top_word) ? DONE : ACCEPT;
            default: state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (decoded from the state register only)
    // ------------------------------------------------------------------
    always_comb begin
        op_ready  = 1'b0;
        mem_we    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        dbg_state = state;
        case (state)
            ACCEPT:  begin op_ready = 1'b1; busy = 1'b1; end
            WRITE:   begin mem_we   = 1'b1; busy = 1'b1; end
            DONE:    begin done     = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q  <= '0;
            count_q <= '0;
            word_q  <= '0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        addr_q  <= {base_addr[ADDR_WIDTH-1:2], 2'b00};
                        count_q <= '0;
                        err_q   <= 1'b0;
                    end
                end
                ACCEPT: begin
                    if (accept) begin
                        word_q <= DATA_WIDTH'(enc_word);
                        last_q <= last;
                        if (enc_bad) err_q <= 1'b1;
                    end
                end
                WRITE: begin
                    addr_q  <= addr_q + ADDR_WIDTH'(4);
                    count_q <= count_q + ADDR_WIDTH'(1);
                    // Running out of memory before the requester said last.
                    if (top_word && !last_q) err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = word_q;
    assign count     = count_q;
    assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// -----------------------------------------------------------------------------
// tb_instr_encoder_loader
//
// Self-checking bench for instr_encoder_loader: reset checks, a table of
// single-instruction sessions with hand-derived words, hand-written multi-cycle
// sequences (held op_valid, top-of-memory overflow, mid-session reset) and
// randomized sessions checked against an arithmetic encoding model.
// -----------------------------------------------------------------------------
module tb_instr_encoder_loader;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int W  = AW + DW;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic          op_valid;
    logic          op_ready;
    logic [3:0]    op_kind;
    logic [4:0]    rd, rs1, rs2;
    logic [31:0]   imm;
    logic          last;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          busy, done, err;
    logic [AW-1:0] count;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    instr_encoder_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
        .op_valid(op_valid), .op_ready(op_ready), .op_kind(op_kind),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm), .last(last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count),
        .dbg_state(dbg_state)
    );

    // ------------------------------------------------------------------
    // Checking core
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // ------------------------------------------------------------------
    // Reference encoder: fields assembled with shifts and masks straight
    // from the RV32I layouts, legality judged on the signed value.
    // ------------------------------------------------------------------
    function automatic void ref_encode(input int unsigned kind, input int unsigned d,
                                       input int unsigned s1, input int unsigned s2,
                                       input int im, output logic [31:0] w, output bit bad);
        int unsigned f3i[4] = '{0, 2, 6, 7};
        int unsigned f3b[6] = '{0, 1, 4, 5, 6, 7};
        bit [31:0] u;
        bit [31:0] r;
        u   = im;
        bad = 0;
        r   = 0;
        if (kind <= 3) begin
            r = ((u & 32'hfff) << 20) | (s1 << 15) | (f3i[kind] << 12) | (d << 7) | 32'h13;
`ifdef ENCODER_RANGE_CHECK_EN
            bad = (im < -2048) || (im > 2047);
`endif
        end else if (kind == 4 || kind == 13) begin
            r = ((u & 32'hfff) << 20) | (s1 << 15) | ((kind == 4 ? 2 : 0) << 12)
              | (d << 7) | (kind == 4 ? 32'h03 : 32'h67);
`ifdef ENCODER_RANGE_CHECK_EN
            bad = (im < -2048) || (im > 2047);
`endif
        end else if (kind == 5) begin
            r = (((u >> 5) & 32'h7f) << 25) | (s2 << 20) | (s1 << 15) | (2 << 12)
              | ((u & 32'h1f) << 7) | 32'h23;
`ifdef ENCODER_RANGE_CHECK_EN
            bad = (im < -2048) || (im > 2047);
`endif
        end else if (kind >= 6 && kind <= 11) begin
            r = (((u >> 12) & 1) << 31) | (((u >> 5) & 32'h3f) << 25) | (s2 << 20)
              | (s1 << 15) | (f3b[kind-6] << 12) | (((u >> 1) & 32'hf) << 8)
              | (((u >> 11) & 1) << 7) | 32'h63;
`ifdef ENCODER_RANGE_CHECK_EN
            bad = (im < -4096) || (im > 4094) || ((im % 2) != 0);
`endif
        end else if (kind == 12) begin
            r = (((u >> 20) & 1) << 31) | (((u >> 1) & 32'h3ff) << 21)
              | (((u >> 11) & 1) << 20) | (((u >> 12) & 32'hff) << 12)
              | (d << 7) | 32'h6f;
`ifdef ENCODER_RANGE_CHECK_EN
            bad = (im < -1048576) || (im > 1048574) || ((im % 2) != 0);
`endif
        end else begin
            bad = 1;
        end
        w = bad ? NOP : r;
    endfunction

    // ------------------------------------------------------------------
    // Session model and scoreboard
    // ------------------------------------------------------------------
    logic [W-1:0]  exp_q[$];
    logic [AW-1:0] m_addr;
    int            m_count;
    bit            m_err;
    bit            m_end;
    int            acc_cyc;
    bit            prev_we = 1'b0;

    always @(negedge clk) begin
        if (mem_we) begin
            logic [W-1:0] e;
            check("we_not_back_to_back", 32'(prev_we), 32'd0);
            check("ready_low_in_write", 32'(op_ready), 32'd0);
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("mem_addr", 32'(mem_addr), 32'(e[W-1:DW]));
                check("mem_wdata", mem_wdata, e[DW-1:0]);
            end
        end
        prev_we = mem_we;
    end

    // ------------------------------------------------------------------
    // Driver tasks (all enter and leave just after a rising edge)
    // ------------------------------------------------------------------
    task automatic start_session(input logic [AW-1:0] base);
        m_addr    = {base[AW-1:2], 2'b00};
        m_count   = 0;
        m_err     = 0;
        m_end     = 0;
        base_addr = base;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        base_addr = 8'($urandom);
        @(negedge clk);
        check("ready_after_start", 32'(op_ready), 32'd1);
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_cleared_by_start", 32'(err), 32'd0);
        check("count_cleared_by_start", 32'(count), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_op(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                           input logic [4:0] s2, input logic [31:0] im, input bit lst,
                           input bit hold, input int gap, input bit poke);
        bit ok = 0;
        if (gap > 0) begin
            op_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        op_kind  = k; rd = d; rs1 = s1; rs2 = s2; imm = im; last = lst;
        op_valid = 1'b1;
        start    = poke;   // start while busy must be ignored
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (op_ready) begin
                @(posedge clk); #1;
                acc_cyc = cyc;
                ok = 1;
                break;
            end
        end
        start = 1'b0;
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: op_ready not seen within 20 cycles, required 1");
        end
        if (!hold || !ok) op_valid = 1'b0;
    endtask

    // Books the expected write into the model, then drives the request.
    task automatic issue(input logic [3:0] k, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] im, input bit lst,
                         input bit hold, input int gap, input bit poke,
                         input logic [31:0] ew, input bit eb);
        bit top;
        exp_q.push_back({m_addr, ew});
        top = (m_addr[AW-1:2] == '1);
        if (eb) m_err = 1;
        if (top && !lst) m_err = 1;
        m_end   = lst || top;
        m_addr  = m_addr + 8'd4;
        m_count = m_count + 1;
        send_op(k, d, s1, s2, im, lst, hold, gap, poke);
    endtask

    task automatic wait_done();
        bit seen = 0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check("done_seen", 32'(seen), 32'd1);
        if (seen) begin
            check("done_latency", 32'(cyc - acc_cyc), 32'd1);
            check("count_at_done", 32'(count), 32'(m_count));
            check("err_at_done", 32'(err), 32'(m_err));
            @(negedge clk);
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_after_done", 32'(busy), 32'd0);
            check("err_sticky", 32'(err), 32'(m_err));
        end
        @(posedge clk); #1;
    endtask

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    typedef struct {
        logic [3:0]  kind;
        logic [4:0]  rd, rs1, rs2;
        logic [31:0] imm;
        logic [31:0] exp_word;
        bit          exp_err;
    } vec_t;

    vec_t vecs[10];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int bl[12] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, -4098,
                       -1048576, 1048574, 1048576, 3};
        int p_acc;
        logic [31:0] w;
        bit b;

        vecs[0] = '{4'd0,  5'd1,  5'd0,  5'd0, 32'd5,         32'h0050_0093, 1'b0};
        vecs[1] = '{4'd5,  5'd7,  5'd1,  5'd2, 32'd8,         32'h0020_A423, 1'b0};
        vecs[2] = '{4'd7,  5'd0,  5'd1,  5'd0, -32'sd4,       32'hFE00_9EE3, 1'b0};
        vecs[3] = '{4'd12, 5'd1,  5'd3,  5'd4, 32'd8,         32'h0080_00EF, 1'b0};
        vecs[4] = '{4'd15, 5'd1,  5'd2,  5'd3, 32'd1,         NOP,           1'b1};
        vecs[5] = '{4'd4,  5'd2,  5'd3,  5'd9, 32'hFFFF_FFFF, 32'hFFF1_A103, 1'b0};
        vecs[6] = '{4'd13, 5'd1,  5'd5,  5'd6, 32'd0,         32'h0002_80E7, 1'b0};
        vecs[7] = '{4'd3,  5'd31, 5'd31, 5'd0, 32'd2047,      32'h7FFF_FF93, 1'b0};
`ifdef ENCODER_RANGE_CHECK_EN
        vecs[8] = '{4'd0,  5'd1,  5'd0,  5'd0, 32'd2048,      NOP,           1'b1};
        vecs[9] = '{4'd6,  5'd0,  5'd0,  5'd0, 32'd3,         NOP,           1'b1};
`else
        vecs[8] = '{4'd0,  5'd1,  5'd0,  5'd0, 32'd2048,      32'h8000_0093, 1'b0};
        vecs[9] = '{4'd6,  5'd0,  5'd0,  5'd0, 32'd3,         32'h0000_0163, 1'b0};
`endif

        rst = 1'b1; start = 1'b0; base_addr = '0; op_valid = 1'b0;
        op_kind = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0; last = 1'b0;
        acc_cyc = 0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_op_ready", 32'(op_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table: one instruction per session, last=1
        for (int i = 0; i < 10; i++) begin
            start_session(8'h40 + 8'(i * 4));
            issue(vecs[i].kind, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                  1'b1, 1'b0, 0, 1'b0, vecs[i].exp_word, vecs[i].exp_err);
            wait_done();
        end

        // Base 0x13 (low bits ignored), three ADDIs with op_valid held high
        start_session(8'h13);
        p_acc = 0;
        for (int i = 0; i < 3; i++) begin
            ref_encode(0, i + 1, 0, 0, i, w, b);
            issue(4'd0, 5'(i + 1), 5'd0, 5'd0, 32'(i), (i == 2), (i != 2), 0, 1'b0, w, b);
            if (i > 0) check("held_valid_spacing", 32'(acc_cyc - p_acc), 32'd2);
            p_acc = acc_cyc;
        end
        wait_done();

        // Top-of-memory: base 0xF8, last never set
        start_session(8'hF8);
        ref_encode(2, 3, 4, 0, 1, w, b);
        issue(4'd2, 5'd3, 5'd4, 5'd0, 32'd1, 1'b0, 1'b0, 0, 1'b0, w, b);
        check("not_end_before_top", 32'(m_end), 32'd0);
        issue(4'd2, 5'd3, 5'd4, 5'd0, 32'd1, 1'b0, 1'b0, 0, 1'b0, w, b);
        wait_done();
        check("top_overflow_err", 32'(err), 32'd1);
        check("top_overflow_count", 32'(count), 32'd2);

        // Reset during WRITE: the write in progress is visible this cycle,
        // then every output is back at its reset value and no done follows.
        start_session(8'h20);
        issue(4'd14, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 1'b0, 0, 1'b0, NOP, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("midrst_mem_we", 32'(mem_we), 32'd0);
        check("midrst_op_ready", 32'(op_ready), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        check("midrst_count", 32'(count), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        check("midrst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;
        for (int t = 0; t < 4; t++) begin
            @(negedge clk);
            check("midrst_no_done", 32'(done), 32'd0);
            check("midrst_stays_idle", 32'(busy), 32'd0);
        end
        @(posedge clk); #1;

        // Randomized sessions against the reference model
        for (int s = 0; s < 30; s++) begin
            int nops;
            start_session(8'($urandom_range(0, 255)));
            nops = $urandom_range(1, 6);
            for (int j = 0; j < nops; j++) begin
                logic [3:0]  k;
                logic [4:0]  d, s1, s2;
                logic [31:0] im;
                int          sel;
                bit          lst;
                k  = ($urandom_range(0, 7) == 0) ? 4'(14 + $urandom_range(0, 1))
                                                 : 4'($urandom_range(0, 13));
                d  = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
                sel = $urandom_range(0, 2);
                if (sel == 0)      im = 32'($signed($urandom_range(0, 80)) - 40);
                else if (sel == 1) im = 32'(bl[$urandom_range(0, 11)]);
                else               im = $urandom;
                lst = (j == nops - 1);
                ref_encode(k, d, s1, s2, int'(im), w, b);
                issue(k, d, s1, s2, im, lst, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 2), 1'($urandom_range(0, 1)), w, b);
                if (m_end) break;
            end
            op_valid = 1'b0;
            wait_done();
        end

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
